// File: rtl/dzcpu_uop_sequencer_pkg.sv
// dzcpu_uop_sequencer_pkg: flow codes, states and uop layout shared by the uop sequencer
package dzcpu_uop_sequencer_pkg;
    localparam logic [7:0] IRQ_FLOW_IDX = 8'd175;
    localparam logic [7:0] CB_OPCODE    = 8'hCB;
    localparam logic [3:0] OP_JCB       = 4'hF;
    typedef enum logic [3:0] {
        FL_OP           = 4'd0,
        FL_INC          = 4'd1,
        FL_EOF          = 4'd2,
        FL_INC_EOF      = 4'd3,
        FL_EOF_FU       = 4'd4,
        FL_INC_EOF_FU   = 4'd5,
        FL_INC_EOF_Z    = 4'd6,
        FL_INC_EOF_NZ   = 4'd7,
        FL_UPDATE_FLAGS = 4'd8,
        FL_NOP          = 4'd9
    } flow_t;
    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_CB,
        S_CB_DECODE
    } state_t;
    // 13-bit ROM word: flow[12:9], op[8:5], operand[4:0]
    typedef struct packed {
        flow_t      flow;
        logic [3:0] op;
        logic [4:0] operand;
    } uop_t;
endpackage

// File: rtl/dzcpu_uop_sequencer_if.sv
// dzcpu_uop_sequencer_if: opcode fetch, microcode table and datapath signals of the uop sequencer
interface dzcpu_uop_sequencer_if;
    logic [7:0]  iMop;
    logic        iMopValid;
    logic [7:0]  oMop;
    logic [7:0]  iFlowIdx;
    logic [7:0]  iCbFlowIdx;
    logic [7:0]  oUopAddr;
    logic [12:0] iUop;
    logic        oUopValid;
    logic        iUopReady;
    logic [3:0]  oUopOp;
    logic [4:0]  oUopOperand;
    logic        oIncPc;
    logic        oUpdateFlags;
    logic        iFlagZ;
    logic        oEof;
    logic        iIrqPending;
    logic        oIrqAck;
    logic        oError;
    modport master (
        input  iMop, iMopValid, iFlowIdx, iCbFlowIdx, iUop, iUopReady, iFlagZ, iIrqPending,
        output oMop, oUopAddr, oUopValid, oUopOp, oUopOperand, oIncPc, oUpdateFlags, oEof, oIrqAck, oError
    );
    modport slave (
        output iMop, iMopValid, iFlowIdx, iCbFlowIdx, iUop, iUopReady, iFlagZ, iIrqPending,
        input  oMop, oUopAddr, oUopValid, oUopOp, oUopOperand, oIncPc, oUpdateFlags, oEof, oIrqAck, oError
    );
endinterface

// File: rtl/dzcpu_useq_flowdec.sv
// dzcpu_useq_flowdec: decodes a uop flow field (and Z for conditional eof) into sequencing actions
module dzcpu_useq_flowdec
    import dzcpu_uop_sequencer_pkg::*;
(
    input  flow_t flow,
    input  logic  flag_z,
    output logic  advance,
    output logic  retire,
    output logic  inc_pc,
    output logic  upd_flags
);
    assign retire = (flow inside {FL_EOF, FL_INC_EOF, FL_EOF_FU, FL_INC_EOF_FU})
                  || (flow == FL_INC_EOF_Z && flag_z)
                  || (flow == FL_INC_EOF_NZ && !flag_z);
    assign advance = !retire;
    assign inc_pc = flow inside {FL_INC, FL_INC_EOF, FL_INC_EOF_FU, FL_INC_EOF_Z, FL_INC_EOF_NZ};
    assign upd_flags = flow inside {FL_EOF_FU, FL_INC_EOF_FU, FL_UPDATE_FLAGS};
endmodule

// File: rtl/dzcpu_uop_sequencer.sv
// dzcpu_uop_sequencer: opcode -> flow index -> micro-PC stepping through the uop ROM, issuing uops over valid/ready
module dzcpu_uop_sequencer
    import dzcpu_uop_sequencer_pkg::*;
(
    input logic                   iClock,
    input logic                   iReset,
    dzcpu_uop_sequencer_if.master bus
);
    state_t     state, state_nxt;
    logic [7:0] upc, upc_nxt;
    logic [7:0] mop;
    uop_t       uop_q;
    logic       in_irq, in_irq_nxt;
    logic       err, err_nxt;
    logic       hs, jcb, take_irq;
    logic       advance, retire, inc_pc, upd_flags;

    dzcpu_useq_flowdec u_flowdec (
        .flow      (uop_q.flow),
        .flag_z    (bus.iFlagZ),
        .advance   (advance),
        .retire    (retire),
        .inc_pc    (inc_pc),
        .upd_flags (upd_flags)
    );

    assign hs       = state == S_EXEC && bus.iUopReady;
    assign jcb      = uop_q.op == OP_JCB;
    assign take_irq = hs && !jcb && retire && bus.iIrqPending && !in_irq;

    // The ROM is addressed with the next micro-PC so the registered uop lines up with uPC without a bubble;
    // while stalled the next micro-PC equals uPC, keeping the word stable.
    assign bus.oUopAddr     = upc_nxt;
    assign bus.oMop         = mop;
    assign bus.oUopValid    = state == S_EXEC;
    assign bus.oUopOp       = uop_q.op;
    assign bus.oUopOperand  = uop_q.operand;
    assign bus.oIncPc       = hs && inc_pc;
    assign bus.oUpdateFlags = hs && upd_flags;
    assign bus.oEof         = hs && !jcb && retire;
    assign bus.oIrqAck      = take_irq;
    assign bus.oError       = err;

    // Next state and micro-PC; nothing moves in S_EXEC until the datapath accepts the uop.
    always_comb begin
        state_nxt  = state;
        upc_nxt    = upc;
        in_irq_nxt = in_irq;
        err_nxt    = err;
        case (state)
            S_FETCH: state_nxt = bus.iMopValid ? S_DECODE : S_FETCH;
            S_CB: state_nxt = bus.iMopValid ? S_CB_DECODE : S_CB;
            S_DECODE, S_CB_DECODE: begin
                upc_nxt   = state == S_DECODE ? bus.iFlowIdx : bus.iCbFlowIdx;
                state_nxt = S_EXEC;
            end
            default: if (hs) begin
                if (jcb) begin
                    state_nxt = S_CB;
                end else if (take_irq) begin
                    upc_nxt    = IRQ_FLOW_IDX;
                    in_irq_nxt = 1'b1;
                end else if (retire) begin
                    state_nxt  = S_FETCH;
                    in_irq_nxt = 1'b0;
                end else if (advance && upc == 8'hFF) begin
                    state_nxt  = S_FETCH;
                    in_irq_nxt = 1'b0;
                    err_nxt    = 1'b1;
                end else if (advance) begin
                    upc_nxt = upc + 8'd1;
                end
            end
        endcase
    end

    // State, micro-PC, opcode and presented uop registers; uop fields are cleared whenever nothing is issued.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state  <= S_FETCH;
            upc    <= '0;
            mop    <= '0;
            uop_q  <= '0;
            in_irq <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            upc    <= upc_nxt;
            in_irq <= in_irq_nxt;
            err    <= err_nxt;
            uop_q  <= state_nxt == S_EXEC ? uop_t'(bus.iUop) : '0;
            if ((state == S_FETCH || state == S_CB) && bus.iMopValid)
                mop <= bus.iMop;
        end
    end
endmodule

// File: tb/tb_dzcpu_uop_sequencer.sv
// tb_dzcpu_uop_sequencer: table-driven cycle vectors plus directed corner sequences for the uop sequencer
module tb_dzcpu_uop_sequencer;
    import dzcpu_uop_sequencer_pkg::*;

    typedef struct {
        logic       mv;
        logic [7:0] mop, fidx, cbidx;
        logic       z, irq;
        logic       v;
        logic [7:0] pa;
        logic       inc, upd, eof, ack;
    } vec_t;

    logic        clk, rst_n;
    logic [12:0] rom [256];
    int          checks, errors;
    vec_t        vq[$];

    dzcpu_uop_sequencer_if bus();

    dzcpu_uop_sequencer dut (
        .iClock (clk),
        .iReset (rst_n),
        .bus    (bus)
    );

    assign bus.iUop = rom[bus.oUopAddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] word(input int a, input flow_t f);
        logic [7:0] b;
        b = 8'(a);
        return {f, 1'b0, b[7:5], b[4:0]};
    endfunction

    function automatic vec_t mk(input logic mv, input logic [7:0] mop, fidx, cbidx, input logic z, irq, v,
                                input logic [7:0] pa, input logic inc, upd, eof, ack);
        vec_t r;
        r = '{mv, mop, fidx, cbidx, z, irq, v, pa, inc, upd, eof, ack};
        return r;
    endfunction

    function automatic logic [31:0] all_out();
        return {1'b0, bus.oMop, bus.oUopAddr, bus.oUopValid, bus.oUopOp, bus.oUopOperand,
                bus.oIncPc, bus.oUpdateFlags, bus.oEof, bus.oIrqAck, bus.oError};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic mv, input logic [7:0] mop, fidx, cbidx, input logic rdy, z, irq);
        @(negedge clk);
        bus.iMopValid   = mv;
        bus.iMop        = mop;
        bus.iFlowIdx    = fidx;
        bus.iCbFlowIdx  = cbidx;
        bus.iUopReady   = rdy;
        bus.iFlagZ      = z;
        bus.iIrqPending = irq;
        #1;
    endtask

    task automatic expect_out(input string nm, input logic v, input logic [7:0] pa, input logic inc, upd, eof, ack);
        logic [12:0] w;
        w = v ? rom[pa] : 13'd0;
        check(nm, {18'd0, bus.oUopValid, bus.oUopOp, bus.oUopOperand, bus.oIncPc, bus.oUpdateFlags, bus.oEof, bus.oIrqAck},
                  {18'd0, v, w[8:5], w[4:0], inc, upd, eof, ack});
    endtask

    task automatic idle(input string nm);
        drive(0, 0, 0, 0, 1, 0, 0);
        expect_out(nm, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int a = 0; a < 256; a++) rom[a] = word(a, FL_OP);
        rom[0]   = word(0, FL_INC_EOF);
        rom[1]   = word(1, FL_INC);
        rom[2]   = word(2, FL_INC);
        rom[4]   = word(4, FL_INC_EOF);
        rom[15]  = {FL_INC, OP_JCB, 5'd15};
        rom[16]  = word(16, FL_EOF_FU);
        rom[17]  = word(17, FL_INC);
        rom[19]  = word(19, FL_INC_EOF_Z);
        rom[22]  = word(22, FL_EOF);
        rom[53]  = word(53, FL_EOF);
        rom[100] = word(100, FL_UPDATE_FLAGS);
        rom[101] = word(101, FL_NOP);
        rom[102] = word(102, FL_INC_EOF_NZ);
        rom[103] = word(103, FL_INC_EOF_FU);
        rom[176] = word(176, FL_EOF);

        // LDSPnn, then a 1-byte flow back-to-back with LDSPnn taking an interrupt at its eof
        vq.push_back(mk(1, 8'h31,   1, 0, 0, 0, 0,   0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0,       1, 0, 0, 0, 0,   0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0,       0, 0, 0, 0, 1,   1, 1, 0, 0, 0));
        vq.push_back(mk(0, 0,       0, 0, 0, 0, 1,   2, 1, 0, 0, 0));
        vq.push_back(mk(0, 0,       0, 0, 0, 0, 1,   3, 0, 0, 0, 0));
        vq.push_back(mk(0, 0,       0, 0, 0, 0, 1,   4, 1, 0, 1, 0));
        vq.push_back(mk(0, 0,       0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
        vq.push_back(mk(1, 8'h00,   0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0,       0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0,       0, 0, 0, 0, 1,   0, 1, 0, 1, 0));
        vq.push_back(mk(1, 8'h31,   1, 0, 0, 0, 0,   0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0,       1, 0, 0, 0, 0,   0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0,       0, 0, 0, 0, 1,   1, 1, 0, 0, 0));
        vq.push_back(mk(0, 0,       0, 0, 0, 0, 1,   2, 1, 0, 0, 0));
        vq.push_back(mk(0, 0,       0, 0, 0, 0, 1,   3, 0, 0, 0, 0));
        vq.push_back(mk(0, 0,       0, 0, 0, 1, 1,   4, 1, 0, 1, 1));
        vq.push_back(mk(0, 0,       0, 0, 0, 1, 1, 175, 0, 0, 0, 0));
        vq.push_back(mk(0, 0,       0, 0, 0, 1, 1, 176, 0, 0, 1, 0));
        vq.push_back(mk(0, 0,       0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
        // CB prefix: jcb at 15, second byte 0x7C selects CB flow 16
        vq.push_back(mk(1, 8'hCB,  13, 0, 0, 0, 0,   0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0,      13, 0, 0, 0, 0,   0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0,       0, 0, 0, 0, 1,  13, 0, 0, 0, 0));
        vq.push_back(mk(0, 0,       0, 0, 0, 0, 1,  14, 0, 0, 0, 0));
        vq.push_back(mk(0, 0,       0, 0, 0, 0, 1,  15, 1, 0, 0, 0));
        vq.push_back(mk(0, 0,       0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
        vq.push_back(mk(1, 8'h7C,   0, 16, 0, 0, 0,  0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0,       0, 16, 0, 0, 0,  0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0,       0, 0, 0, 0, 1,  16, 0, 1, 1, 0));
        vq.push_back(mk(0, 0,       0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
        // JRNZ with Z=1 (retires at 19) then Z=0 (runs on to 22)
        vq.push_back(mk(1, 8'h20,  17, 0, 0, 0, 0,   0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0,      17, 0, 0, 0, 0,   0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0,       0, 0, 0, 0, 1,  17, 1, 0, 0, 0));
        vq.push_back(mk(0, 0,       0, 0, 0, 0, 1,  18, 0, 0, 0, 0));
        vq.push_back(mk(0, 0,       0, 0, 1, 0, 1,  19, 1, 0, 1, 0));
        vq.push_back(mk(0, 0,       0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
        vq.push_back(mk(1, 8'h20,  17, 0, 0, 0, 0,   0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0,      17, 0, 0, 0, 0,   0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0,       0, 0, 0, 0, 1,  17, 1, 0, 0, 0));
        vq.push_back(mk(0, 0,       0, 0, 0, 0, 1,  18, 0, 0, 0, 0));
        vq.push_back(mk(0, 0,       0, 0, 0, 0, 1,  19, 1, 0, 0, 0));
        vq.push_back(mk(0, 0,       0, 0, 0, 0, 1,  20, 0, 0, 0, 0));
        vq.push_back(mk(0, 0,       0, 0, 0, 0, 1,  21, 0, 0, 0, 0));
        vq.push_back(mk(0, 0,       0, 0, 0, 0, 1,  22, 0, 0, 1, 0));
        vq.push_back(mk(0, 0,       0, 0, 0, 1, 0,   0, 0, 0, 0, 0));
        // update_flags, nop, NZ not taken, inc_eof_fu
        vq.push_back(mk(1, 8'h10, 100, 0, 0, 0, 0,   0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0,     100, 0, 0, 0, 0,   0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0,       0, 0, 0, 0, 1, 100, 0, 1, 0, 0));
        vq.push_back(mk(0, 0,       0, 0, 0, 0, 1, 101, 0, 0, 0, 0));
        vq.push_back(mk(0, 0,       0, 0, 1, 0, 1, 102, 1, 0, 0, 0));
        vq.push_back(mk(0, 0,       0, 0, 0, 0, 1, 103, 1, 1, 1, 0));
        vq.push_back(mk(0, 0,       0, 0, 0, 0, 0,   0, 0, 0, 0, 0));

        // Reset held with random inputs: every output stays 0
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            check($sformatf("reset_hold%0d", i), all_out(), 0);
        end
        rst_n = 1'b1;
        drive(0, 8'h55, 8'h44, 8'h33, 1, 1, 1);
        check("reset_release0", all_out(), 0);
        drive(0, 8'h55, 8'h44, 8'h33, 1, 1, 1);
        check("reset_release1", all_out(), 0);

        foreach (vq[i]) begin
            drive(vq[i].mv, vq[i].mop, vq[i].fidx, vq[i].cbidx, 1, vq[i].z, vq[i].irq);
            expect_out($sformatf("vec%0d", i), vq[i].v, vq[i].pa, vq[i].inc, vq[i].upd, vq[i].eof, vq[i].ack);
            if (i == 26) check("cb_mop", {24'd0, bus.oMop}, 32'h7C);
        end
        check("last_mop", {24'd0, bus.oMop}, 32'h10);

        // Backpressure at addr 2 for three cycles
        drive(1, 8'h31, 1, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        expect_out("bp_addr1", 1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            expect_out($sformatf("bp_stall%0d", i), 1, 2, 0, 0, 0, 0);
            check($sformatf("bp_rom_addr%0d", i), {24'd0, bus.oUopAddr}, 2);
        end
        drive(0, 0, 0, 0, 1, 0, 0);
        expect_out("bp_accept2", 1, 2, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        expect_out("bp_resume3", 1, 3, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        expect_out("bp_eof4", 1, 4, 1, 0, 1, 0);
        idle("bp_done");

        // Asynchronous reset in the middle of a flow, while uop 52 is presented
        drive(1, 8'h50, 50, 0, 1, 0, 0);
        drive(0, 0, 50, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        expect_out("ar_at52", 1, 52, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1 check("ar_immediate", all_out(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle("ar_after");

        // Micro-PC overflow from 0xFF: sticky error, back to fetch
        drive(1, 8'h99, 254, 0, 1, 0, 0);
        drive(0, 0, 254, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        expect_out("ovf_254", 1, 254, 0, 0, 0, 0);
        check("ovf_err_before", {31'd0, bus.oError}, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        expect_out("ovf_255", 1, 255, 0, 0, 0, 0);
        idle("ovf_fetch");
        check("ovf_err_set", {31'd0, bus.oError}, 1);
        drive(1, 8'h00, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        expect_out("ovf_next_instr", 1, 0, 1, 0, 1, 0);
        check("ovf_err_sticky", {31'd0, bus.oError}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
